// File: rtl/me_load_arbiter.sv
// Load-bus arbiter for the motion-estimation register files: grants current-block or
// search-window refills and streams BEATS memory words into the selected file.
module me_load_arbiter #(
    parameter int DATA_W    = 64,
    parameter int BEATS     = 32,
    parameter int PRIO_MODE = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cur_req,
    input  logic              i_srch_req,
    input  logic              i_flush,
    input  logic              i_mem_valid,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic              o_mem_ready,
    output logic              o_mem_start,
    output logic              o_mem_sel,
    output logic [DATA_W-1:0] o_data_out,
    output logic              o_cur_WE,
    output logic              o_search_WE,
    output logic              o_cur_filled,
    output logic              o_src_filled,
    output logic              o_busy
);
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_XFER, S_DONE} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic              r_last_grant;
    logic              r_settle;
    logic              r_mem_ready;
    logic              r_mem_start;
    logic              r_mem_sel;
    logic [DATA_W-1:0] r_data_out;
    logic              r_cur_we;
    logic              r_srch_we;
    logic              r_cur_filled;
    logic              r_src_filled;
    logic              r_busy;

    logic w_any_req;
    logic w_sel;
    logic w_accept;

    always_comb begin
        w_any_req = i_cur_req | i_srch_req;
        w_sel     = i_srch_req;
        if (i_cur_req && i_srch_req) begin
            w_sel = (PRIO_MODE == 1) ? 1'b0 : ~r_last_grant;
        end
    end

    assign w_accept = (r_state == S_XFER) && r_mem_ready && i_mem_valid;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_beat_cnt   <= '0;
            r_last_grant <= 1'b1;
            r_settle     <= 1'b0;
            r_mem_ready  <= 1'b0;
            r_mem_start  <= 1'b0;
            r_mem_sel    <= 1'b0;
            r_data_out   <= '0;
            r_cur_we     <= 1'b0;
            r_srch_we    <= 1'b0;
            r_cur_filled <= 1'b0;
            r_src_filled <= 1'b0;
            r_busy       <= 1'b0;
        end else if (i_flush) begin
            // Abort wins over everything, including a beat accepted this very cycle.
            r_state      <= S_IDLE;
            r_beat_cnt   <= '0;
            r_settle     <= 1'b0;
            r_mem_ready  <= 1'b0;
            r_mem_start  <= 1'b0;
            r_cur_we     <= 1'b0;
            r_srch_we    <= 1'b0;
            r_cur_filled <= 1'b0;
            r_src_filled <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_mem_start <= 1'b0;
            r_cur_we    <= 1'b0;
            r_srch_we   <= 1'b0;
            if (w_accept) begin
                r_data_out <= i_mem_data;
                r_cur_we   <= ~r_mem_sel;
                r_srch_we  <= r_mem_sel;
            end
            case (r_state)
                S_IDLE: begin
                    // One idle cycle after a fill lets requesters see filled before re-sampling.
                    r_settle <= 1'b0;
                    if (!r_settle && w_any_req) begin
                        r_state      <= S_GRANT;
                        r_busy       <= 1'b1;
                        r_mem_start  <= 1'b1;
                        r_mem_sel    <= w_sel;
                        r_last_grant <= w_sel;
                        r_beat_cnt   <= '0;
                        if (w_sel) begin
                            r_src_filled <= 1'b0;
                        end else begin
                            r_cur_filled <= 1'b0;
                        end
                    end
                end
                S_GRANT: begin
                    r_state     <= S_XFER;
                    r_mem_ready <= 1'b1;
                end
                S_XFER: begin
                    if (w_accept) begin
                        if (r_beat_cnt == LAST_BEAT) begin
                            r_state     <= S_DONE;
                            r_mem_ready <= 1'b0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_settle <= 1'b1;
                    if (r_mem_sel) begin
                        r_src_filled <= 1'b1;
                    end else begin
                        r_cur_filled <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_mem_ready  = r_mem_ready;
    assign o_mem_start  = r_mem_start;
    assign o_mem_sel    = r_mem_sel;
    assign o_data_out   = r_data_out;
    assign o_cur_WE     = r_cur_we;
    assign o_search_WE  = r_srch_we;
    assign o_cur_filled = r_cur_filled;
    assign o_src_filled = r_src_filled;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_me_load_arbiter.sv
// Bench for me_load_arbiter: one instance per priority mode on shared stimulus, each
// tracked by a burst-level scoreboard, plus table vectors and directed corner sequences.
module tb_me_load_arbiter;
    localparam int DATA_W = 64;
    localparam int BEATS  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cur_req = 1'b0, srch_req = 1'b0, flush = 1'b0, mem_valid = 1'b0;
    logic [DATA_W-1:0] mem_data = '0;

    logic              o_ready[2], o_start[2], o_sel[2], o_cwe[2], o_swe[2];
    logic              o_cf[2], o_sf[2], o_busy[2];
    logic [DATA_W-1:0] o_data[2];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        me_load_arbiter #(.DATA_W(DATA_W), .BEATS(BEATS), .PRIO_MODE(gi)) u_dut (
            .i_clk       (clk),
            .i_reset     (rst),
            .i_cur_req   (cur_req),
            .i_srch_req  (srch_req),
            .i_flush     (flush),
            .i_mem_valid (mem_valid),
            .i_mem_data  (mem_data),
            .o_mem_ready (o_ready[gi]),
            .o_mem_start (o_start[gi]),
            .o_mem_sel   (o_sel[gi]),
            .o_data_out  (o_data[gi]),
            .o_cur_WE    (o_cwe[gi]),
            .o_search_WE (o_swe[gi]),
            .o_cur_filled(o_cf[gi]),
            .o_src_filled(o_sf[gi]),
            .o_busy      (o_busy[gi])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard state, one slot per instance (slot 1 has fixed current-block priority).
    int   cyc = 0;
    logic m_active[2], m_sel[2], m_last[2], m_cf[2], m_sf[2];
    int   m_start_cyc[2], m_acc[2], m_done_cyc[2], m_next_ok[2];
    logic pend_v[2], pend_sel[2];
    logic [DATA_W-1:0] pend_data[2];
    logic prev_ok = 1'b0, prev_flush = 1'b0, prev_cur = 1'b0, prev_srch = 1'b0;
    logic acc0_flag = 1'b0;
    int   cwe_cnt[2], swe_cnt[2];
    logic g_log0[$], g_log1[$];
    int   s_log0[$];
    logic [DATA_W-1:0] data_log0[$];

    initial begin
        logic exp_start, sel, exp_ready;
        forever begin
            @(negedge clk);
            cyc++;
            acc0_flag = 1'b0;
            if (rst) begin
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("reset_ctl_d%0d", d),
                        64'({o_ready[d], o_start[d], o_sel[d], o_cwe[d], o_swe[d], o_cf[d], o_sf[d], o_busy[d]}), 64'd0);
                    chk($sformatf("reset_data_d%0d", d), o_data[d], 64'd0);
                    m_active[d] = 1'b0; m_last[d] = 1'b1; m_cf[d] = 1'b0; m_sf[d] = 1'b0;
                    m_next_ok[d] = 0; m_acc[d] = 0; pend_v[d] = 1'b0; m_sel[d] = 1'b0;
                    cwe_cnt[d] = 0; swe_cnt[d] = 0;
                end
                g_log0.delete(); g_log1.delete(); s_log0.delete(); data_log0.delete();
                prev_ok = 1'b0; prev_flush = 1'b0;
            end else begin
                for (int d = 0; d < 2; d++) begin
                    exp_start = prev_ok && !prev_flush && (prev_cur || prev_srch)
                                && !m_active[d] && (cyc >= m_next_ok[d]);
                    sel = 1'b0;
                    if (exp_start) begin
                        if (prev_cur && prev_srch) sel = (d == 1) ? 1'b0 : ~m_last[d];
                        else                       sel = prev_srch;
                        m_last[d] = sel; m_sel[d] = sel; m_active[d] = 1'b1;
                        m_start_cyc[d] = cyc; m_acc[d] = 0;
                        if (sel) m_sf[d] = 1'b0; else m_cf[d] = 1'b0;
                        if (d == 0) begin g_log0.push_back(sel); s_log0.push_back(cyc); end
                        else g_log1.push_back(sel);
                    end
                    exp_ready = m_active[d] && (cyc > m_start_cyc[d]) && (m_acc[d] < BEATS);
                    chk($sformatf("mem_start_d%0d_c%0d", d, cyc), 64'(o_start[d]), 64'(exp_start));
                    chk($sformatf("mem_ready_d%0d_c%0d", d, cyc), 64'(o_ready[d]), 64'(exp_ready));
                    chk($sformatf("busy_d%0d_c%0d", d, cyc), 64'(o_busy[d]), 64'(m_active[d]));
                    chk($sformatf("cur_we_d%0d_c%0d", d, cyc), 64'(o_cwe[d]), 64'(pend_v[d] && !pend_sel[d]));
                    chk($sformatf("srch_we_d%0d_c%0d", d, cyc), 64'(o_swe[d]), 64'(pend_v[d] && pend_sel[d]));
                    chk($sformatf("cur_filled_d%0d_c%0d", d, cyc), 64'(o_cf[d]), 64'(m_cf[d]));
                    chk($sformatf("src_filled_d%0d_c%0d", d, cyc), 64'(o_sf[d]), 64'(m_sf[d]));
                    if (m_active[d]) chk($sformatf("mem_sel_d%0d_c%0d", d, cyc), 64'(o_sel[d]), 64'(m_sel[d]));
                    if (pend_v[d]) chk($sformatf("data_out_d%0d_c%0d", d, cyc), o_data[d], pend_data[d]);
                    if (o_cwe[d]) cwe_cnt[d]++;
                    if (o_swe[d]) begin
                        swe_cnt[d]++;
                        if (d == 0) data_log0.push_back(o_data[d]);
                    end
                    pend_v[d] = 1'b0;
                    if (flush) begin
                        m_active[d] = 1'b0; m_cf[d] = 1'b0; m_sf[d] = 1'b0;
                    end else begin
                        if (exp_ready && mem_valid) begin
                            pend_v[d] = 1'b1; pend_sel[d] = m_sel[d]; pend_data[d] = mem_data;
                            m_acc[d]++;
                            if (m_acc[d] == BEATS) m_done_cyc[d] = cyc + 1;
                            if (d == 0) acc0_flag = 1'b1;
                        end
                        if (m_active[d] && m_acc[d] == BEATS && cyc == m_done_cyc[d]) begin
                            m_active[d] = 1'b0;
                            if (m_sel[d]) m_sf[d] = 1'b1; else m_cf[d] = 1'b1;
                            m_next_ok[d] = cyc + 3;
                            $display("[TB] dut%0d fill sel=%0d complete at cycle %0d", d, m_sel[d], cyc);
                        end
                    end
                end
                prev_cur = cur_req; prev_srch = srch_req; prev_flush = flush; prev_ok = 1'b1;
            end
        end
    end

    // Stimulus helpers: inputs change 1 time unit after each rising edge.
    int   word_idx = 0;
    logic data_rand = 1'b0;

    task automatic cycle();
        @(posedge clk);
        #1;
        if (acc0_flag) word_idx++;
        mem_data = data_rand ? {$urandom, $urandom} : DATA_W'(word_idx);
    endtask

    task automatic do_reset();
        rst = 1'b1; cur_req = 1'b0; srch_req = 1'b0; flush = 1'b0; mem_valid = 1'b0;
        cycle(); cycle();
        word_idx = 0;
        rst = 1'b0;
    endtask

    task automatic wait_start(input int d, input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (o_start[d]) begin ok = 1'b1; break; end
        end
        chk({name, "_start_seen"}, 64'(ok), 64'd1);
    endtask

    task automatic drain(input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            cycle();
            if (!o_busy[0] && !o_busy[1]) begin ok = 1'b1; break; end
        end
        chk({name, "_drained"}, 64'(ok), 64'd1);
        cycle();
    endtask

    typedef struct {
        logic cur;
        logic srch;
        logic exp_start;
        logic exp_sel0;
        logic exp_sel1;
    } vec_t;

    initial begin
        vec_t vecs[4];
        logic seen[2], got_sel[2];
        bit   ok;
        vecs[0] = '{cur: 1'b1, srch: 1'b0, exp_start: 1'b1, exp_sel0: 1'b0, exp_sel1: 1'b0};
        vecs[1] = '{cur: 1'b0, srch: 1'b1, exp_start: 1'b1, exp_sel0: 1'b1, exp_sel1: 1'b1};
        vecs[2] = '{cur: 1'b1, srch: 1'b1, exp_start: 1'b1, exp_sel0: 1'b0, exp_sel1: 1'b0};
        vecs[3] = '{cur: 1'b0, srch: 1'b0, exp_start: 1'b0, exp_sel0: 1'b0, exp_sel1: 1'b0};

        // First grant out of reset for each request pattern.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            cur_req = vecs[r].cur; srch_req = vecs[r].srch;
            seen = '{1'b0, 1'b0}; got_sel = '{1'b0, 1'b0};
            for (int n = 0; n < 6; n++) begin
                cycle();
                for (int d = 0; d < 2; d++)
                    if (o_start[d] && !seen[d]) begin seen[d] = 1'b1; got_sel[d] = o_sel[d]; end
            end
            cur_req = 1'b0; srch_req = 1'b0;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("tbl%0d_start_d%0d", r, d), 64'(seen[d]), 64'(vecs[r].exp_start));
                if (vecs[r].exp_start)
                    chk($sformatf("tbl%0d_sel_d%0d", r, d), 64'(got_sel[d]),
                        64'((d == 0) ? vecs[r].exp_sel0 : vecs[r].exp_sel1));
            end
            flush = 1'b1; cycle(); flush = 1'b0; cycle();
        end

        // Single current-block fill with a continuously valid stream.
        do_reset();
        mem_valid = 1'b1; cur_req = 1'b1;
        wait_start(0, "t1");
        chk("t1_sel", 64'(o_sel[0]), 64'd0);
        chk("t1_ready_in_grant", 64'(o_ready[0]), 64'd0);
        cur_req = 1'b0;
        drain("t1");
        chk("t1_cur_we_count", 64'(cwe_cnt[0]), 64'(BEATS));
        chk("t1_srch_we_count", 64'(swe_cnt[0]), 64'd0);
        chk("t1_cur_filled", 64'(o_cf[0]), 64'd1);

        // Both requests held: round-robin order and back-to-back spacing.
        do_reset();
        mem_valid = 1'b1; cur_req = 1'b1; srch_req = 1'b1;
        for (int n = 0; n < 200 && g_log0.size() < 3; n++) cycle();
        cur_req = 1'b0; srch_req = 1'b0;
        chk("t2_grants", 64'(g_log0.size()), 64'd3);
        if (g_log0.size() >= 3) begin
            chk("t2_order0", 64'(g_log0[0]), 64'd0);
            chk("t2_order1", 64'(g_log0[1]), 64'd1);
            chk("t2_order2", 64'(g_log0[2]), 64'd0);
            chk("t2_gap", 64'(s_log0[1] - s_log0[0]), 64'(BEATS + 4));
        end
        drain("t2");

        // Fixed priority: current block starves search until cur_req drops.
        do_reset();
        mem_valid = 1'b1; cur_req = 1'b1; srch_req = 1'b1;
        for (int n = 0; n < 200 && g_log1.size() < 3; n++) cycle();
        cur_req = 1'b0;
        for (int n = 0; n < 100 && g_log1.size() < 4; n++) cycle();
        srch_req = 1'b0;
        chk("t3_grants", 64'(g_log1.size()), 64'd4);
        if (g_log1.size() >= 4) begin
            chk("t3_g0", 64'(g_log1[0]), 64'd0);
            chk("t3_g1", 64'(g_log1[1]), 64'd0);
            chk("t3_g2", 64'(g_log1[2]), 64'd0);
            chk("t3_g3", 64'(g_log1[3]), 64'd1);
        end
        drain("t3");

        // Search fill with a stream that is valid every other cycle.
        do_reset();
        srch_req = 1'b1; mem_valid = 1'b0;
        wait_start(0, "t4");
        srch_req = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            mem_valid = ~mem_valid;
            cycle();
            if (!o_busy[0]) begin ok = 1'b1; break; end
        end
        mem_valid = 1'b0;
        chk("t4_done", 64'(ok), 64'd1);
        chk("t4_srch_we_count", 64'(data_log0.size()), 64'(BEATS));
        chk("t4_cur_we_count", 64'(cwe_cnt[0]), 64'd0);
        for (int i = 0; i < data_log0.size(); i++)
            chk($sformatf("t4_word%0d", i), data_log0[i], 64'(i));
        cycle();
        chk("t4_src_filled", 64'(o_sf[0]), 64'd1);

        // Flush at beat 10 of a current-block fill, then a clean refill.
        do_reset();
        mem_valid = 1'b1; cur_req = 1'b1;
        wait_start(0, "t5a");
        cur_req = 1'b0;
        for (int n = 0; n < 40 && m_acc[0] < 10; n++) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("t5_busy_after_flush", 64'(o_busy[0]), 64'd0);
        chk("t5_ready_after_flush", 64'(o_ready[0]), 64'd0);
        chk("t5_cur_we_after_flush", 64'(o_cwe[0]), 64'd0);
        chk("t5_cur_filled", 64'(o_cf[0]), 64'd0);
        chk("t5_we_count", 64'(cwe_cnt[0]), 64'd10);
        for (int n = 0; n < 4; n++) cycle();
        chk("t5_no_late_we", 64'(cwe_cnt[0]), 64'd10);
        cur_req = 1'b1;
        wait_start(0, "t5b");
        cur_req = 1'b0;
        drain("t5");
        chk("t5_refill_we_count", 64'(cwe_cnt[0]), 64'(10 + BEATS));
        chk("t5_refill_filled", 64'(o_cf[0]), 64'd1);

        // Asynchronous reset in the middle of a search fill.
        do_reset();
        mem_valid = 1'b1; srch_req = 1'b1;
        wait_start(0, "t6a");
        srch_req = 1'b0;
        for (int n = 0; n < 20 && m_acc[0] < 5; n++) cycle();
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++)
            chk($sformatf("t6_async_clear_d%0d", d),
                64'({o_ready[d], o_start[d], o_cwe[d], o_swe[d], o_cf[d], o_sf[d], o_busy[d]}), 64'd0);
        cycle(); cycle();
        rst = 1'b0;
        srch_req = 1'b1;
        wait_start(0, "t6b");
        srch_req = 1'b0;
        drain("t6");
        chk("t6_srch_we_count", 64'(swe_cnt[0]), 64'(BEATS));
        chk("t6_src_filled", 64'(o_sf[0]), 64'd1);
        chk("t6_cur_filled", 64'(o_cf[0]), 64'd0);

        // Random requests, stalls and occasional flushes against the scoreboard.
        do_reset();
        data_rand = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) cur_req = ~cur_req;
            if ($urandom_range(0, 7) == 0) srch_req = ~srch_req;
            mem_valid = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 199) == 0);
            cycle();
        end
        flush = 1'b0; cur_req = 1'b0; srch_req = 1'b0; mem_valid = 1'b1;
        chk("rand_activity", 64'(g_log0.size() > 5), 64'd1);
        drain("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
